// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Opcodes, state encodings and control-field codes shared by
//                the multicycle MIPS control FSM and the ALU decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       beq;
        logic       bne;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_word_t;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_R)   || (op == OP_LW)  || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_J);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
// ============================================================================
//  Module      : mips_ctrl_outdec
//  Description : Decodes the control FSM state into the datapath control word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]  i_state,
    input  logic [5:0]  i_opcode,
    input  logic        i_mem_ready,
    output ctrl_word_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b  = SRCB_IMMSH2;
                o_ctrl.alu_op     = ALUOP_ADD;
                // Unrecognised opcodes retire here as a NOP
                o_ctrl.instr_done = ~is_known_op(i_opcode);
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord       = 1'b1;
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a  = 1'b1;
                o_ctrl.alu_src_b  = SRCB_REG;
                o_ctrl.alu_op     = ALUOP_SUB;
                o_ctrl.pc_src     = PCSRC_ALUOUT;
                o_ctrl.beq        = (i_opcode == OP_BEQ);
                o_ctrl.bne        = (i_opcode == OP_BNE);
                o_ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_src     = PCSRC_JUMP;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Main control FSM of the multicycle MIPS core; state register
//                and next-state logic, outputs decoded by mips_ctrl_outdec.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] Opcode,
    input  logic           mem_ready,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           PCWrite,
    output logic           Beq,
    output logic           Bne,
    output logic           RegDst,
    output logic           MemtoReg,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSrc,
    output logic [STW-1:0] state_o,
    output logic           instr_done
);

    logic [STW-1:0] r_state;
    logic [STW-1:0] w_next_state;
    ctrl_word_t     w_ctrl;

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:   w_next_state = S_MEMADR;
                    OP_R:           w_next_state = S_EXEC;
                    OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
                    OP_ADDI:        w_next_state = S_ADDIEX;
                    OP_J:           w_next_state = S_JUMP;
                    default:        w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (Opcode)
                    OP_LW:   w_next_state = S_MEMRD;
                    OP_SW:   w_next_state = S_MEMWR;
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next_state = S_ALUWB;
            S_ADDIEX: w_next_state = S_ADDIWB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    mips_ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_opcode    (Opcode),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign IorD       = w_ctrl.iord;
    assign MemRead    = w_ctrl.mem_read;
    assign MemWrite   = w_ctrl.mem_write;
    // A fetch under reset must never commit the IR or PC
    assign IRWrite    = w_ctrl.ir_write & ~reset;
    assign PCWrite    = w_ctrl.pc_write & ~reset;
    assign Beq        = w_ctrl.beq;
    assign Bne        = w_ctrl.bne;
    assign RegDst     = w_ctrl.reg_dst;
    assign MemtoReg   = w_ctrl.mem_to_reg;
    assign RegWrite   = w_ctrl.reg_write;
    assign ALUSrcA    = w_ctrl.alu_src_a;
    assign ALUSrcB    = w_ctrl.alu_src_b;
    assign ALUOp      = w_ctrl.alu_op;
    assign PCSrc      = w_ctrl.pc_src;
    assign instr_done = w_ctrl.instr_done;
    assign state_o    = r_state;

endmodule

`default_nettype wire
